// File: rtl/acia_pkg.sv
// acia_pkg: shared constants and types for the acia_uart ACIA.
//   Register select codes, STATUS bit positions, CONTROL field codes,
//   data/counter widths, TX/RX state enums and a STATUS packing helper.
package acia_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;

    // Register select
    localparam logic REG_STAT = 1'b0;
    localparam logic REG_DATA = 1'b1;

    // STATUS bit indices
    localparam int unsigned ST_RDRF = 0;
    localparam int unsigned ST_TDRE = 1;
    localparam int unsigned ST_FE   = 4;
    localparam int unsigned ST_OVRN = 5;
    localparam int unsigned ST_IRQ  = 7;

    // CONTROL field codes
    localparam logic [1:0] CTL_MRESET = 2'b11;
    localparam logic [1:0] CTL_TIE    = 2'b01;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Assemble the STATUS byte; unlisted bits read 0.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic rdrf,
        input logic tdre,
        input logic fe,
        input logic ovrn,
        input logic irq
    );
        logic [DATA_W-1:0] st;
        st          = '0;
        st[ST_RDRF] = rdrf;
        st[ST_TDRE] = tdre;
        st[ST_FE]   = fe;
        st[ST_OVRN] = ovrn;
        st[ST_IRQ]  = irq;
        return st;
    endfunction

endpackage

// File: rtl/acia_baud_gen.sv
// acia_baud_gen: free-running 16x baud tick generator.
//   clk, rst   : system clock, synchronous active-high reset
//   tick16     : one-clk pulse every DIV clocks,
//                DIV = CLK_FREQ/(BAUD_RATE*16) truncated, minimum 1
module acia_baud_gen #(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic tick16
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // Divider counter; tick16 is registered alongside the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            tick16 <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt    <= '0;
            tick16 <= 1'b1;
        end else begin
            cnt    <= cnt + CNT_W'(1);
            tick16 <= 1'b0;
        end
    end

endmodule

// File: rtl/acia_uart.sv
// acia_uart: memory-mapped 6850-style ACIA, 8N1 TX/RX with level interrupt.
//   clk, rst      : system clock, synchronous active-high reset
//   cs, we, rs    : bus strobe, write(1)/read(0), register select (0 STAT/CTL, 1 DATA)
//   din / dout    : write data / registered read data (1 clk latency)
//   rx / tx       : serial in (async, idle high) / serial out (idle high)
//   irq           : (RIE & RDRF) | (TIE & TDRE)
// Build option: define ACIA_ERR_EN to implement FE/OVRN (STATUS bits 4/5);
// otherwise those bits read 0 and their registers are omitted.
module acia_uart
    import acia_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 12000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              rs,
    input  logic              rx,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx,
    output logic              irq
);

    logic tick16;

    acia_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .tick16 (tick16)
    );

    // Bus decode
    logic wr_ctl_c, wr_data_c, rd_c, rd_data_c, mreset_c;
    assign rd_c      = cs & ~we;
    assign rd_data_c = rd_c & (rs == REG_DATA);
    assign wr_ctl_c  = cs & we & (rs == REG_STAT);
    assign wr_data_c = cs & we & (rs == REG_DATA);
    assign mreset_c  = wr_ctl_c & (din[1:0] == CTL_MRESET);

    logic unused_din;
    assign unused_din = ^din[4:2];

    // Register file / flags
    logic              rie, tie, rdrf, tdre;
    logic [DATA_W-1:0] thr, rx_data;
    logic              fe, ovrn;
    logic [DATA_W-1:0] status_c;

    // TX datapath
    tx_state_t         tx_state, tx_state_n;
    logic [TICK_W-1:0] tx_tick, tx_tick_n;
    logic [BIT_W-1:0]  tx_bit, tx_bit_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              tx_n, tx_load_c, tx_bit_end_c;

    // RX datapath
    logic              rx_s1, rx_s2;
    rx_state_t         rx_state, rx_state_n;
    logic [TICK_W-1:0] rx_tick, rx_tick_n;
    logic [BIT_W-1:0]  rx_bit, rx_bit_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic              rx_done_c;

    assign irq      = (rie & rdrf) | (tie & tdre);
    assign status_c = pack_status(rdrf, tdre, fe, ovrn, irq);

    // ---------------------------------------------------------------- TX
    // TX state register; master reset aborts the frame like rst.
    always_ff @(posedge clk) begin
        if (rst || mreset_c) begin
            tx_state <= TX_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_tick  <= tx_tick_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
        end
    end

    // TX next state; loads only on a tick so the start bit is a full 16 ticks.
    always_comb begin
        tx_state_n   = tx_state;
        tx_tick_n    = tx_tick;
        tx_bit_n     = tx_bit;
        tx_shift_n   = tx_shift;
        tx_n         = tx;
        tx_load_c    = 1'b0;
        tx_bit_end_c = tick16 && (tx_tick == TICK_W'(15));

        if (tick16 && (tx_state != TX_IDLE)) begin
            tx_tick_n = tx_tick + TICK_W'(1);
        end

        case (tx_state)
            TX_IDLE: begin
                if (tick16 && !tdre) begin
                    tx_load_c  = 1'b1;
                    tx_shift_n = thr;
                    tx_tick_n  = '0;
                    tx_n       = 1'b0;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end_c) begin
                    tx_bit_n   = '0;
                    tx_n       = tx_shift[0];
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_end_c) begin
                    if (tx_bit == BIT_W'(7)) begin
                        tx_n       = 1'b1;
                        tx_state_n = TX_STOP;
                    end else begin
                        tx_shift_n = tx_shift >> 1;
                        tx_bit_n   = tx_bit + BIT_W'(1);
                        tx_n       = tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_bit_end_c) begin
                    if (!tdre) begin
                        // back-to-back frame
                        tx_load_c  = 1'b1;
                        tx_shift_n = thr;
                        tx_n       = 1'b0;
                        tx_state_n = TX_START;
                    end else begin
                        tx_n       = 1'b1;
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX
    // Two-flop synchronizer; reset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst || mreset_c) begin
            rx_state <= RX_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_tick  <= rx_tick_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next state; start is re-checked 8 ticks in, then sampled every 16.
    always_comb begin
        rx_state_n = rx_state;
        rx_tick_n  = rx_tick;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_done_c  = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_tick_n  = '0;
                    rx_state_n = RX_START;
                end
            end
            RX_START: begin
                if (tick16) begin
                    if (rx_tick == TICK_W'(7)) begin
                        rx_tick_n  = '0;
                        rx_bit_n   = '0;
                        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_n = rx_tick + TICK_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick16) begin
                    rx_tick_n = rx_tick + TICK_W'(1);
                    if (rx_tick == TICK_W'(15)) begin
                        rx_shift_n = {rx_s2, rx_shift[DATA_W-1:1]};
                        if (rx_bit == BIT_W'(7)) begin
                            rx_state_n = RX_STOP;
                        end else begin
                            rx_bit_n = rx_bit + BIT_W'(1);
                        end
                    end
                end
            end
            RX_STOP: begin
                if (tick16) begin
                    rx_tick_n = rx_tick + TICK_W'(1);
                    if (rx_tick == TICK_W'(15)) begin
                        rx_done_c  = 1'b1;
                        rx_state_n = RX_IDLE;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------- registers
    // Control, holding register, RDRF/TDRE, RX data and read-data capture.
    // Receive completion outranks a clearing DATA read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rie     <= 1'b0;
            tie     <= 1'b0;
            thr     <= '0;
            tdre    <= 1'b1;
            rdrf    <= 1'b0;
            rx_data <= '0;
            dout    <= '0;
        end else begin
            if (wr_ctl_c) begin
                rie <= din[7];
                tie <= (din[6:5] == CTL_TIE);
            end
            if (wr_data_c) begin
                thr <= din;
            end
            if (mreset_c) begin
                tdre <= 1'b1;
            end else if (wr_data_c) begin
                tdre <= 1'b0;
            end else if (tx_load_c) begin
                tdre <= 1'b1;
            end
            if (mreset_c) begin
                rdrf <= 1'b0;
            end else if (rx_done_c) begin
                rdrf <= 1'b1;
            end else if (rd_data_c) begin
                rdrf <= 1'b0;
            end
            if (rx_done_c && !mreset_c) begin
                rx_data <= rx_shift;
            end
            if (rd_c) begin
                dout <= (rs == REG_DATA) ? rx_data : status_c;
            end
        end
    end

`ifdef ACIA_ERR_EN
    // Framing / overrun flags.
    always_ff @(posedge clk) begin
        if (rst || mreset_c) begin
            fe   <= 1'b0;
            ovrn <= 1'b0;
        end else if (rx_done_c) begin
            fe <= ~rx_s2;
            if (rdrf) begin
                ovrn <= 1'b1;
            end else if (rd_data_c) begin
                ovrn <= 1'b0;
            end
        end else if (rd_data_c) begin
            fe   <= 1'b0;
            ovrn <= 1'b0;
        end
    end
`else
    assign fe   = 1'b0;
    assign ovrn = 1'b0;
`endif

endmodule

// File: tb/tb_acia_uart.sv
// tb_acia_uart: directed self-checking bench for acia_uart
// (CLK_FREQ=3200, BAUD_RATE=100 -> DIV=2, 32 clks per bit).
module tb_acia_uart;

    localparam int unsigned BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst, cs, we, rs, rx;
    logic [7:0] din, dout;
    logic       tx, irq;

    int vectors     = 0;
    int miscompares = 0;

    acia_uart #(
        .CLK_FREQ  (3200),
        .BAUD_RATE (100)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .rs   (rs),
        .rx   (rx),
        .din  (din),
        .dout (dout),
        .tx   (tx),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All bus/serial tasks start and end just after a falling edge.
    task automatic bus_write(input logic sel, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; rs = sel; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; din = 8'h00;
    endtask

    task automatic bus_read(input logic sel, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; rs = sel;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 8N1 frame on rx; a bad stop bit is held low only past its mid-sample.
    task automatic send_rx(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            rx = 1'b0;
            wait_clks(24);
            rx = 1'b1;
            wait_clks(40);
        end
    endtask

    task automatic wait_tx_low(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (tx == 1'b0) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        logic [9:0] frame;
        int         tx_lows;

        rst = 1'b1; cs = 1'b0; we = 1'b0; rs = 1'b0; rx = 1'b1; din = 8'h00;
        wait_clks(5);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_dout", 16'(dout), 16'h00);
        check("rst_tx", 16'(tx), 16'h1);
        check("rst_irq", 16'(irq), 16'h0);
        bus_read(1'b0, rd);
        check("rst_status", 16'(rd), 16'h02);

        // TIE: code 01 enables, 11 does not
        bus_write(1'b0, 8'h20);
        check("tie_irq_on", 16'(irq), 16'h1);
        bus_read(1'b0, rd);
        check("tie_status", 16'(rd), 16'h82);
        bus_write(1'b0, 8'h60);
        check("tie_irq_off", 16'(irq), 16'h0);

        // Transmit 0xA5
        bus_write(1'b1, 8'hA5);
        bus_read(1'b0, rd);
        check("tx_status_pending", 16'(rd), 16'h00);
        wait_tx_low(100);
        check("tx_start_seen", 16'(tx), 16'h0);
        wait_clks(16);
        for (int i = 0; i < 10; i++) begin
            frame[i] = tx;
            if (i < 9) wait_clks(BIT_CLKS);
        end
        check("tx_frame", 16'(frame), 16'({1'b1, 8'hA5, 1'b0}));
        wait_clks(20);
        check("tx_idle", 16'(tx), 16'h1);
        bus_read(1'b0, rd);
        check("tx_status_done", 16'(rd), 16'h02);

        // Receive 0x3C (no interrupts enabled)
        send_rx(8'h3C, 1'b1);
        bus_read(1'b0, rd);
        check("rx_status_full", 16'(rd), 16'h03);
        check("rx_irq_masked", 16'(irq), 16'h0);
        bus_read(1'b1, rd);
        check("rx_data", 16'(rd), 16'h3C);
        bus_read(1'b0, rd);
        check("rx_status_clr", 16'(rd), 16'h02);

        // Receive interrupt
        bus_write(1'b0, 8'h80);
        check("rie_irq_idle", 16'(irq), 16'h0);
        send_rx(8'h55, 1'b1);
        check("rie_irq_set", 16'(irq), 16'h1);
        bus_read(1'b0, rd);
        check("rie_status", 16'(rd), 16'h83);
        bus_read(1'b1, rd);
        check("rie_data", 16'(rd), 16'h55);
        check("rie_irq_drop", 16'(irq), 16'h0);

        // Overrun: two bytes without reading
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        bus_read(1'b0, rd);
`ifdef ACIA_ERR_EN
        check("ovrn_status", 16'(rd), 16'hA3);
`else
        check("ovrn_status", 16'(rd), 16'h83);
`endif
        bus_read(1'b1, rd);
        check("ovrn_data", 16'(rd), 16'h22);
        bus_read(1'b0, rd);
        check("ovrn_clr", 16'(rd), 16'h02);

        // Framing error: stop bit low
        send_rx(8'h0F, 1'b0);
        bus_read(1'b0, rd);
`ifdef ACIA_ERR_EN
        check("fe_status", 16'(rd), 16'h93);
`else
        check("fe_status", 16'(rd), 16'h83);
`endif
        bus_read(1'b1, rd);
        check("fe_data", 16'(rd), 16'h0F);
        bus_read(1'b0, rd);
        check("fe_clr", 16'(rd), 16'h02);

        // Master reset mid-transmit with a second byte pending
        bus_write(1'b1, 8'h00);
        wait_tx_low(100);
        check("mr_start_seen", 16'(tx), 16'h0);
        wait_clks(50);
        bus_write(1'b1, 8'h00);
        bus_read(1'b0, rd);
        check("mr_pending", 16'(rd), 16'h00);
        check("mr_tx_busy", 16'(tx), 16'h0);
        bus_write(1'b0, 8'h03);
        check("mr_tx_high", 16'(tx), 16'h1);
        bus_read(1'b0, rd);
        check("mr_status", 16'(rd), 16'h02);
        tx_lows = 0;
        for (int i = 0; i < 400; i++) begin
            if (tx == 1'b0) tx_lows++;
            @(negedge clk);
        end
        check("mr_tx_quiet", 16'(tx_lows), 16'h0);
        check("mr_irq", 16'(irq), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
